// File: rtl/ahbl_sram_slave.sv
// AHB-Lite slave fronting a word-organised SRAM with WAIT_STATES data-phase stall cycles.
// Define AHBL_SRAM_ERR_RESP_EN to give out-of-range or oversized transfers a two-cycle ERROR response.
module ahbl_sram_slave #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [24:0] REGION_BYTES = 25'(DEPTH * 4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           err2_q, err2_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [1:0]     lo_q, lo_d;
    logic [2:0]     size_q, size_d;
    logic           write_q, write_d;

    logic [31:0]    mem_q [DEPTH];

    logic           accept;
    logic           is_err;
    state_t         accept_state;
    logic [3:0]     wmask;
    logic           unused_bits;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            3'd0:    m = 4'b0001 << lo;
            3'd1:    m = lo[1] ? 4'b1100 : 4'b0011;
            3'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Only take a new address phase while this slave itself is ready; WAIT/ERR-1 never accept.
    assign accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;

`ifdef AHBL_SRAM_ERR_RESP_EN
    assign is_err = ({1'b0, HADDR[23:0]} >= REGION_BYTES) || (HSIZE > 3'd2);
`else
    assign is_err = 1'b0;
`endif

    assign unused_bits = ^{HADDR, HTRANS[0]};

    always_comb begin
        if (is_err) begin
            accept_state = ST_ERR;
        end else if (WAIT_STATES > 0) begin
            accept_state = ST_WAIT;
        end else begin
            accept_state = ST_DATA;
        end
    end

    // State register
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            err2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err2_q  <= err2_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err2_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DATA: begin
                state_d = accept ? accept_state : ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR: begin
                if (!err2_q) begin
                    err2_d = 1'b1;
                end else begin
                    state_d = accept ? accept_state : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept && accept_state == ST_WAIT) begin
            cnt_d = WS_LOAD;
        end
    end

    // Output logic
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'h0;
        case (state_q)
            ST_WAIT: HREADYOUT = 1'b0;
            ST_DATA: begin
                if (!write_q) begin
                    HRDATA = mem_q[idx_q];
                end
            end
            ST_ERR: begin
                HREADYOUT = err2_q;
                HRESP     = 1'b1;
            end
            default: ;
        endcase
    end

    // Address-phase capture; data-path registers carry no reset.
    always_comb begin
        idx_d   = idx_q;
        lo_d    = lo_q;
        size_d  = size_q;
        write_d = write_q;
        if (accept) begin
            idx_d   = HADDR[AW+1:2];
            lo_d    = HADDR[1:0];
            size_d  = HSIZE;
            write_d = HWRITE;
        end
    end

    always_ff @(posedge HCLK) begin
        idx_q   <= idx_d;
        lo_q    <= lo_d;
        size_q  <= size_d;
        write_q <= write_d;
    end

    assign wmask = lane_mask(size_q, lo_q);

    // A reset on the closing edge abandons the write.
    always_ff @(posedge HCLK) begin
        if (HRESETn && state_q == ST_DATA && write_q) begin
            for (int n = 0; n < 4; n++) begin
                if (wmask[n]) begin
                    mem_q[idx_q][8*n +: 8] <= HWDATA[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Randomised self-checking bench for ahbl_sram_slave: two instances (0 and 2 wait states)
// driven one at a time and compared against a byte-level memory model.
module tb_ahbl_sram_slave;

    localparam int DEPTH = 1024;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        hsel_drv;
    logic        sel;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;

    logic        HSEL0, HSEL2;
    logic        HREADY0, HREADY2;
    logic        HREADYOUT0, HREADYOUT2;
    logic        HRESP0, HRESP2;
    logic [31:0] HRDATA0, HRDATA2;

    logic        rdy, resp;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [int];

    always #5 HCLK = ~HCLK;

    assign HSEL0   = hsel_drv & ~sel;
    assign HSEL2   = hsel_drv & sel;
    assign HREADY0 = HREADYOUT0;
    assign HREADY2 = HREADYOUT2;
    assign rdy     = sel ? HREADYOUT2 : HREADYOUT0;
    assign resp    = sel ? HRESP2 : HRESP0;
    assign rdata   = sel ? HRDATA2 : HRDATA0;

    ahbl_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL0), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY0),
        .HRDATA(HRDATA0), .HREADYOUT(HREADYOUT0), .HRESP(HRESP0)
    );

    ahbl_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL2), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY2),
        .HRDATA(HRDATA2), .HREADYOUT(HREADYOUT2), .HRESP(HRESP2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int mkey(input logic [31:0] a);
        return int'(sel) * DEPTH + (int'(a[23:0]) % (DEPTH * 4)) / 4;
    endfunction

    function automatic bit is_err_m(input logic [31:0] a, input logic [2:0] sz);
`ifdef AHBL_SRAM_ERR_RESP_EN
        return (int'(a[23:0]) >= DEPTH * 4) || (sz > 3'd2);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int k, first, nbytes;
        logic [31:0] w;
        k = mkey(a);
        w = mdl.exists(k) ? mdl[k] : 32'h0;
        first  = 0;
        nbytes = 0;
        if (sz == 3'd0) begin
            first = int'(a[1:0]);
            nbytes = 1;
        end else if (sz == 3'd1) begin
            first = (int'(a[1:0]) / 2) * 2;
            nbytes = 2;
        end else if (sz == 3'd2) begin
            nbytes = 4;
        end
        for (int b = 0; b < 4; b++) begin
            if (b >= first && b < first + nbytes) w[8*b +: 8] = wd[8*b +: 8];
        end
        mdl[k] = w;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int k;
        k = mkey(a);
        return mdl.exists(k) ? mdl[k] : 32'h0;
    endfunction

    // One non-pipelined transfer; checks stall count, HRESP and (for reads) the data.
    task automatic xfer(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                        input logic [31:0] wd, input string tag, output logic [31:0] rd);
        int stalls, exp_stalls;
        logic resp_stall, resp_last;
        logic [31:0] exp_rd;
        bit err;
        err = is_err_m(a, sz);
        exp_stalls = err ? 1 : (sel ? 2 : 0);
        exp_rd = (!wr && !err) ? model_read(a) : 32'h0;
        @(posedge HCLK); #1;
        hsel_drv = 1'b1; HTRANS = 2'b10; HADDR = a; HSIZE = sz; HWRITE = wr;
        @(posedge HCLK); #1;
        hsel_drv = 1'b0; HTRANS = 2'b00; HWDATA = wd;
        stalls = 0;
        resp_stall = 1'b0;
        @(negedge HCLK);
        while (!rdy && stalls < 40) begin
            stalls++;
            resp_stall |= resp;
            @(negedge HCLK);
        end
        rd = rdata;
        resp_last = resp;
        chk({tag, ":stalls"}, 32'(stalls), 32'(exp_stalls));
        chk({tag, ":resp"}, 32'(resp_last), 32'(err));
        chk({tag, ":resp_stall"}, 32'(resp_stall), 32'(err));
        if (!wr) chk({tag, ":rdata"}, rd, exp_rd);
        if (wr && !err) model_write(a, sz, wd);
    endtask

    // Word write immediately followed by a pipelined read of the same word.
    task automatic wr_rd_b2b(input logic [31:0] a, input logic [31:0] wd, input string tag);
        int stalls;
        @(posedge HCLK); #1;
        hsel_drv = 1'b1; HTRANS = 2'b10; HADDR = a; HSIZE = 3'd2; HWRITE = 1'b1;
        @(posedge HCLK); #1;
        HWDATA = wd; HWRITE = 1'b0;
        stalls = 0;
        @(negedge HCLK);
        while (!rdy && stalls < 40) begin
            stalls++;
            @(negedge HCLK);
        end
        chk({tag, ":wr_stalls"}, 32'(stalls), sel ? 32'd2 : 32'd0);
        model_write(a, 3'd2, wd);
        @(posedge HCLK); #1;
        hsel_drv = 1'b0; HTRANS = 2'b00;
        stalls = 0;
        @(negedge HCLK);
        while (!rdy && stalls < 40) begin
            stalls++;
            @(negedge HCLK);
        end
        chk({tag, ":rd_stalls"}, 32'(stalls), sel ? 32'd2 : 32'd0);
        chk({tag, ":rdata"}, rdata, wd);
    endtask

    // Address phase that must not be taken as a transfer.
    task automatic no_xfer(input logic [31:0] a, input logic hs, input logic [1:0] tr, input string tag);
        @(posedge HCLK); #1;
        hsel_drv = hs; HTRANS = tr; HADDR = a; HSIZE = 3'd2; HWRITE = 1'b1;
        @(posedge HCLK); #1;
        hsel_drv = 1'b0; HTRANS = 2'b00; HWDATA = 32'hFFFF_FFFF;
        @(negedge HCLK);
        chk({tag, ":rdy"}, 32'(rdy), 32'd1);
        chk({tag, ":resp"}, 32'(resp), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a, wd;
        logic [2:0]  sz;
        logic        wr;
        int          r;

        HRESETn = 1'b0; hsel_drv = 1'b0; sel = 1'b0;
        HADDR = 32'h0; HTRANS = 2'b00; HSIZE = 3'd0; HWRITE = 1'b0; HWDATA = 32'h0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst0_rdy", 32'(HREADYOUT0), 32'd1);
        chk("rst0_resp", 32'(HRESP0), 32'd0);
        chk("rst0_rdata", HRDATA0, 32'h0);
        chk("rst2_rdy", 32'(HREADYOUT2), 32'd1);
        chk("rst2_resp", 32'(HRESP2), 32'd0);
        chk("rst2_rdata", HRDATA2, 32'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // Directed: zero wait states
        sel = 1'b0;
        xfer(32'h4100_0000, 3'd2, 1'b1, 32'h1234_5678, "d0_wr_word", rd);
        xfer(32'h4100_0000, 3'd2, 1'b0, 32'h0, "d0_rd_word", rd);
        chk("d0_word_const", rd, 32'h1234_5678);
        xfer(32'h4100_0001, 3'd0, 1'b1, 32'h0000_AB00, "d0_wr_byte", rd);
        xfer(32'h4100_0000, 3'd2, 1'b0, 32'h0, "d0_rd_byte", rd);
        chk("d0_byte_const", rd, 32'h1234_AB78);
        xfer(32'h4100_0002, 3'd1, 1'b1, 32'hBEEF_0000, "d0_wr_half", rd);
        xfer(32'h4100_0000, 3'd2, 1'b0, 32'h0, "d0_rd_half", rd);
        chk("d0_half_const", rd, 32'hBEEF_AB78);
        no_xfer(32'h4100_0000, 1'b0, 2'b10, "d0_nosel");
        no_xfer(32'h4100_0000, 1'b1, 2'b01, "d0_busy");
        xfer(32'h4100_0000, 3'd2, 1'b0, 32'h0, "d0_rd_after_nosel", rd);
        chk("d0_nosel_const", rd, 32'hBEEF_AB78);
        xfer(32'h4100_1000, 3'd2, 1'b1, 32'h55AA_55AA, "d0_wr_oob", rd);
        xfer(32'h4100_0000, 3'd2, 1'b0, 32'h0, "d0_rd_after_oob", rd);
`ifdef AHBL_SRAM_ERR_RESP_EN
        chk("d0_oob_const", rd, 32'hBEEF_AB78);
        xfer(32'h4100_0000, 3'd3, 1'b1, 32'h0BAD_0BAD, "d0_wr_size3", rd);
`else
        chk("d0_alias_const", rd, 32'h55AA_55AA);
`endif

        // Directed: two wait states
        sel = 1'b1;
        xfer(32'h4100_0004, 3'd2, 1'b1, 32'hCAFE_F00D, "d2_wr_word", rd);
        xfer(32'h4100_0004, 3'd2, 1'b0, 32'h0, "d2_rd_word", rd);
        chk("d2_word_const", rd, 32'hCAFE_F00D);

        // Reset during the WAIT phase of a write
        @(posedge HCLK); #1;
        hsel_drv = 1'b1; HTRANS = 2'b10; HADDR = 32'h4100_0004; HSIZE = 3'd2; HWRITE = 1'b1;
        @(posedge HCLK); #1;
        hsel_drv = 1'b0; HTRANS = 2'b00; HWDATA = 32'hDEAD_BEEF; HRESETn = 1'b0;
        @(negedge HCLK);
        chk("rstw_in_wait", 32'(rdy), 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("rstw_rdy", 32'(rdy), 32'd1);
        chk("rstw_resp", 32'(resp), 32'd0);
        xfer(32'h4100_0004, 3'd2, 1'b0, 32'h0, "rstw_rd", rd);
        chk("rstw_const", rd, 32'hCAFE_F00D);

        // Seed words 0..15 of both instances, then random traffic
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int w = 0; w < 16; w++) begin
                xfer(32'h4100_0000 + 32'(w * 4), 3'd2, 1'b1, $urandom, "seed", rd);
            end
            for (int i = 0; i < 80; i++) begin
                a = 32'h4100_0000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3) * 4096);
                r = $urandom_range(0, 9);
                sz = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3;
                wr = 1'($urandom_range(0, 1));
                wd = $urandom;
                xfer(a, sz, wr, wd, $sformatf("rnd%0d_%0d", s, i), rd);
                if ((i % 10) == 0) begin
                    wr_rd_b2b(32'h4100_0000 + 32'($urandom_range(0, 15) * 4), $urandom,
                              $sformatf("b2b%0d_%0d", s, i));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
